// File: rtl/tqvp_vga_capture_if.sv
// rtl/tqvp_vga_capture_if.sv - TinyQV peripheral register bus
interface tqvp_vga_capture_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_vga_capture.sv
// rtl/tqvp_vga_capture.sv - RGB222+sync frame capture: line timing and window signature
module tqvp_vga_capture #(
  parameter int WIN_W        = 8,
  parameter int WIN_H        = 8,
  parameter int TIMEOUT_BITS = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           ui_in,
  output logic [7:0]           uo_out,
  output logic                 user_interrupt,
  tqvp_vga_capture_if.slave    bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [10:0] WIN_W11 = 11'(WIN_W);
  localparam logic [10:0] WIN_H11 = 11'(WIN_H);

  state_t state_q, state_d;

  logic                    irq_en, pol;
  logic [9:0]              x0, y0;
  logic [9:0]              hcnt, ycnt;
  logic                    hs_d, vs_d;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic [9:0]              line_len, line_cnt;
  logic [15:0]             sig;
  logic                    timeout, first_seen;

  logic wr_ctrl, wr_win, arm, clr;
  logic hs_act, vs_act, hs_edge, vs_edge;
  logic [TIMEOUT_BITS-1:0] wd_next;
  logic wd_hit, in_window;
  logic [15:0] sig_next;
  logic clear_res, clr_timeout, set_timeout, wd_clr, cap_active;
  logic unused_bits;

  assign wr_ctrl = (bus.data_write_n != 2'b11) && (bus.address == 6'h00);
  assign wr_win  = (bus.data_write_n == 2'b10) && (bus.address == 6'h14);
  assign arm     = wr_ctrl & bus.data_in[0];
  assign clr     = wr_ctrl & bus.data_in[3];

  assign hs_act  = ui_in[6] ^ ~pol;
  assign vs_act  = ui_in[7] ^ ~pol;
  assign hs_edge = hs_act & ~hs_d;
  assign vs_edge = vs_act & ~vs_d;

  // Timeout fires on the cycle the watchdog would become all-ones.
  assign wd_next = wd_q + TIMEOUT_BITS'(1);
  assign wd_hit  = &wd_next;

  assign in_window = ({1'b0, hcnt} >= {1'b0, x0}) && ({1'b0, hcnt} < ({1'b0, x0} + WIN_W11)) &&
                     ({1'b0, ycnt} >= {1'b0, y0}) && ({1'b0, ycnt} < ({1'b0, y0} + WIN_H11));

  assign sig_next = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {10'b0, ui_in[5:0]};

  always_comb begin
    state_d     = state_q;
    clear_res   = 1'b0;
    clr_timeout = 1'b0;
    set_timeout = 1'b0;
    wd_clr      = 1'b0;
    cap_active  = 1'b0;
    if (arm) begin
      state_d   = WAIT_VS;
      clear_res = 1'b1;
    end else if (clr) begin
      state_d     = IDLE;
      clr_timeout = 1'b1;
    end else begin
      case (state_q)
        WAIT_VS: begin
          if (vs_edge) begin
            state_d = CAPTURE;
            wd_clr  = 1'b1;
          end else if (wd_hit) begin
            state_d     = DONE;
            set_timeout = 1'b1;
          end
        end
        CAPTURE: begin
          if (vs_edge) begin
            state_d = DONE;
          end else if (wd_hit) begin
            state_d     = DONE;
            set_timeout = 1'b1;
          end else begin
            cap_active = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_en     <= 1'b0;
      pol        <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      hcnt       <= '0;
      ycnt       <= '0;
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      wd_q       <= '0;
      line_len   <= '0;
      line_cnt   <= '0;
      sig        <= '0;
      timeout    <= 1'b0;
      first_seen <= 1'b0;
    end else begin
      hs_d <= hs_act;
      vs_d <= vs_act;

      if (hs_edge)                hcnt <= '0;
      else if (hcnt != 10'h3ff)   hcnt <= hcnt + 10'd1;

      if (vs_edge)                        ycnt <= '0;
      else if (hs_edge && ycnt != 10'h3ff) ycnt <= ycnt + 10'd1;

      if (wr_ctrl) begin
        irq_en <= bus.data_in[1];
        pol    <= bus.data_in[2];
      end
      if (wr_win) begin
        x0 <= bus.data_in[9:0];
        y0 <= bus.data_in[25:16];
      end

      if (clear_res || wd_clr)                      wd_q <= '0;
      else if (state_q == WAIT_VS || state_q == CAPTURE) wd_q <= wd_next;

      if (clear_res) begin
        line_len   <= '0;
        line_cnt   <= '0;
        sig        <= '0;
        timeout    <= 1'b0;
        first_seen <= 1'b0;
      end else begin
        if (clr_timeout) timeout <= 1'b0;
        if (set_timeout) timeout <= 1'b1;
        if (cap_active) begin
          // The first hsync of the frame only opens a line; its length is unknown.
          if (hs_edge) begin
            line_cnt   <= line_cnt + 10'd1;
            first_seen <= 1'b1;
            if (first_seen) line_len <= hcnt + 10'd1;
          end
          if (in_window) sig <= sig_next;
        end
      end
    end
  end

  always_comb begin
    bus.data_out = 32'h0;
    case (bus.address)
      6'h00: bus.data_out = {29'b0, pol, irq_en, 1'b0};
      6'h04: bus.data_out = {28'b0, state_q == DONE, timeout, state_q};
      6'h08: bus.data_out = {22'b0, line_len};
      6'h0C: bus.data_out = {22'b0, line_cnt};
      6'h10: bus.data_out = {16'b0, sig};
      6'h14: bus.data_out = {6'b0, y0, 6'b0, x0};
      default: ;
    endcase
  end

  assign bus.data_ready = 1'b1;
  assign uo_out         = 8'h00;
  assign user_interrupt = (state_q == DONE) & irq_en;
  assign unused_bits    = &{1'b0, bus.data_read_n, bus.data_in[31:26], bus.data_in[15:10]};

endmodule
